desc_pair_gather: RTL and testbench

DESC_PAIR_GATHER -- requirements
Module: desc_pair_gather

---
 rtl/desc_pair_gather.sv | 131 +++++++++++++
 tb/tb_desc_pair_gather.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/desc_pair_gather.sv
// Gathers one- or two-word descriptors from the core into single records and
// queues them in a first-word-fall-through FIFO for the downstream scheduler.
module desc_pair_gather #(
  parameter int DEPTH      = 4,
  parameter int DESC_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    core_reset,
  input  logic [DESC_WIDTH-1:0]   s_desc,
  input  logic                    s_desc_2nd,
  input  logic                    s_desc_valid,
  output logic                    s_desc_ready,
  output logic [2*DESC_WIDTH-1:0] m_desc,
  output logic                    m_desc_pair,
  output logic                    m_desc_valid,
  input  logic                    m_desc_ready,
  output logic                    pair_err,
  output logic [31:0]             rec_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, WAIT2} state_e;

  state_e                  state_q, state_d;
  logic [DESC_WIDTH-1:0]   lo_q, lo_d;
  logic [AW:0]             wrPtr_q, wrPtr_d;
  logic [AW:0]             rdPtr_q, rdPtr_d;
  logic [31:0]             recCount_q, recCount_d;
  logic                    pairErr_q, pairErr_d;
  logic [2*DESC_WIDTH:0]   mem_q [DEPTH];

  logic                    fifoFull;
  logic                    fifoEmpty;
  logic                    beatAcc;
  logic                    pop;
  logic                    push;
  logic                    pushPair;
  logic [2*DESC_WIDTH-1:0] pushData;
  logic [2*DESC_WIDTH:0]   rdEntry;

  assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign fifoEmpty = (wrPtr_q == rdPtr_q);

  assign s_desc_ready = !fifoFull && !core_reset;
  assign beatAcc      = s_desc_valid && s_desc_ready;
  assign pop          = !fifoEmpty && m_desc_ready && !core_reset;

  // Pairing FSM: a beat flagged 2nd parks in lo_q, the following beat completes it.
  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    push      = 1'b0;
    pushPair  = 1'b0;
    pushData  = '0;
    pairErr_d = 1'b0;
    if (core_reset) begin
      state_d = IDLE;
      lo_d    = '0;
    end else if (beatAcc) begin
      unique case (state_q)
        IDLE: begin
          if (s_desc_2nd) begin
            lo_d    = s_desc;
            state_d = WAIT2;
          end else begin
            push     = 1'b1;
            pushData = {{DESC_WIDTH{1'b0}}, s_desc};
          end
        end
        WAIT2: begin
          push      = 1'b1;
          pushPair  = 1'b1;
          pushData  = {s_desc, lo_q};
          pairErr_d = s_desc_2nd;
          lo_d      = '0;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    recCount_d = recCount_q + {31'd0, pop};
    if (core_reset) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      wrPtr_d = wrPtr_q + {{AW{1'b0}}, push};
      rdPtr_d = rdPtr_q + {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lo_q       <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      recCount_q <= '0;
      pairErr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      recCount_q <= recCount_d;
      pairErr_q  <= pairErr_d;
    end
  end

  // Storage carries no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q[AW-1:0]] <= {pushPair, pushData};
    end
  end

  assign rdEntry      = mem_q[rdPtr_q[AW-1:0]];
  assign m_desc_valid = !fifoEmpty;
  assign m_desc       = m_desc_valid ? rdEntry[2*DESC_WIDTH-1:0] : '0;
  assign m_desc_pair  = m_desc_valid ? rdEntry[2*DESC_WIDTH] : 1'b0;
  assign pair_err     = pairErr_q;
  assign rec_count    = recCount_q;

endmodule

// File: tb/tb_desc_pair_gather.sv
// Directed bench for desc_pair_gather: queue-based record model checked every
// cycle, plus literal expectations for the single/pair/backpressure/error/flush/wrap cases.
module tb_desc_pair_gather;

  localparam int DEPTH = 4;
  localparam int W     = 64;

  typedef struct {
    logic [2*W-1:0] data;
    logic           pair;
  } rec_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           core_reset;
  logic [W-1:0]   s_desc;
  logic           s_desc_2nd;
  logic           s_desc_valid;
  logic           s_desc_ready;
  logic [2*W-1:0] m_desc;
  logic           m_desc_pair;
  logic           m_desc_valid;
  logic           m_desc_ready;
  logic           pair_err;
  logic [31:0]    rec_count;

  int checks = 0;
  int errors = 0;

  rec_t        mq[$];
  logic        mPending = 1'b0;
  logic [W-1:0] mLo = '0;
  logic        mErr = 1'b0;
  logic [31:0] mPops = '0;
  logic [31:0] countBase = '0;

  desc_pair_gather #(.DEPTH(DEPTH), .DESC_WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .core_reset   (core_reset),
    .s_desc       (s_desc),
    .s_desc_2nd   (s_desc_2nd),
    .s_desc_valid (s_desc_valid),
    .s_desc_ready (s_desc_ready),
    .m_desc       (m_desc),
    .m_desc_pair  (m_desc_pair),
    .m_desc_valid (m_desc_valid),
    .m_desc_ready (m_desc_ready),
    .pair_err     (pair_err),
    .rec_count    (rec_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [2*W-1:0] actual,
                             input logic [2*W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic sec,
                               input logic mr, input logic cr);
    s_desc_valid = v;
    s_desc       = d;
    s_desc_2nd   = sec;
    m_desc_ready = mr;
    core_reset   = cr;
    @(posedge clk);
    #1;
  endtask

  // Reference model: records as a queue, pending low word as a flag plus value.
  always @(posedge clk) begin
    logic acc;
    logic doPop;
    if (!rst_n) begin
      mq.delete();
      mPending = 1'b0;
      mLo      = '0;
      mErr     = 1'b0;
      mPops    = '0;
    end else begin
      acc   = s_desc_valid && (mq.size() < DEPTH) && !core_reset;
      doPop = (mq.size() != 0) && m_desc_ready && !core_reset;
      mErr  = 1'b0;
      if (core_reset) begin
        mq.delete();
        mPending = 1'b0;
        mLo      = '0;
      end else begin
        if (doPop) begin
          void'(mq.pop_front());
          mPops = mPops + 32'd1;
        end
        if (acc) begin
          if (!mPending && s_desc_2nd) begin
            mPending = 1'b1;
            mLo      = s_desc;
          end else if (!mPending) begin
            mq.push_back('{data: {{W{1'b0}}, s_desc}, pair: 1'b0});
          end else begin
            mq.push_back('{data: {s_desc, mLo}, pair: 1'b1});
            mErr     = s_desc_2nd;
            mPending = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      checkOutput("m_desc_valid", {127'd0, m_desc_valid}, {127'd0, mq.size() != 0});
      checkOutput("s_desc_ready", {127'd0, s_desc_ready},
                  {127'd0, (mq.size() < DEPTH) && !core_reset});
      checkOutput("pair_err", {127'd0, pair_err}, {127'd0, mErr});
      checkOutput("rec_count", {96'd0, rec_count}, {96'd0, mPops + countBase});
      if (mq.size() != 0) begin
        checkOutput("m_desc", m_desc, mq[0].data);
        checkOutput("m_desc_pair", {127'd0, m_desc_pair}, {127'd0, mq[0].pair});
      end else begin
        checkOutput("m_desc_pair_idle", {127'd0, m_desc_pair}, 128'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n        = 1'b0;
    core_reset   = 1'b0;
    s_desc       = '0;
    s_desc_2nd   = 1'b0;
    s_desc_valid = 1'b0;
    m_desc_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", {127'd0, m_desc_valid}, 128'd0);
    checkOutput("reset_ready", {127'd0, s_desc_ready}, 128'd1);
    checkOutput("reset_pair", {127'd0, m_desc_pair}, 128'd0);
    checkOutput("reset_count", {96'd0, rec_count}, 128'd0);
    rst_n = 1'b1;

    // Single word
    applyStimulus(1'b1, 64'h11, 1'b0, 1'b1, 1'b0);
    checkOutput("single_valid", {127'd0, m_desc_valid}, 128'd1);
    checkOutput("single_data", m_desc, 128'h11);
    checkOutput("single_pair", {127'd0, m_desc_pair}, 128'd0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("single_count", {96'd0, rec_count}, 128'd1);

    // Two-word pair
    applyStimulus(1'b1, 64'hAA, 1'b1, 1'b1, 1'b0);
    checkOutput("pair_not_early", {127'd0, m_desc_valid}, 128'd0);
    applyStimulus(1'b1, 64'hBB, 1'b0, 1'b1, 1'b0);
    checkOutput("pair_data", m_desc, 128'h00000000000000BB_00000000000000AA);
    checkOutput("pair_flag", {127'd0, m_desc_pair}, 128'd1);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("pair_count", {96'd0, rec_count}, 128'd2);

    // Backpressure: five singles offered into a four-deep FIFO
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 64'h21 + 64'(i), 1'b0, 1'b0, 1'b0);
    checkOutput("bp_ready_low", {127'd0, s_desc_ready}, 128'd0);
    checkOutput("bp_head", m_desc, 128'h21);
    applyStimulus(1'b1, 64'h25, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_head2", m_desc, 128'h22);
    checkOutput("bp_ready_back", {127'd0, s_desc_ready}, 128'd1);
    applyStimulus(1'b1, 64'h25, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_drained", {127'd0, m_desc_valid}, 128'd0);
    checkOutput("bp_count", {96'd0, rec_count}, 128'd7);

    // Protocol error: second beat also flagged 2nd
    applyStimulus(1'b1, 64'h1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 64'h2, 1'b1, 1'b1, 1'b0);
    checkOutput("err_data", m_desc, 128'h0000000000000002_0000000000000001);
    checkOutput("err_pair", {127'd0, m_desc_pair}, 128'd1);
    checkOutput("err_pulse", {127'd0, pair_err}, 128'd1);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("err_pulse_end", {127'd0, pair_err}, 128'd0);
    applyStimulus(1'b1, 64'h3, 1'b0, 1'b0, 1'b0);
    checkOutput("err_idle_single", m_desc, 128'h3);
    checkOutput("err_idle_pair", {127'd0, m_desc_pair}, 128'd0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("err_count", {96'd0, rec_count}, 128'd9);

    // Flush with three queued records and a pending low word
    applyStimulus(1'b1, 64'h31, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h32, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h33, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h34, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_valid", {127'd0, m_desc_valid}, 128'd0);
    checkOutput("flush_count", {96'd0, rec_count}, 128'd9);
    applyStimulus(1'b1, 64'h7, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_next_data", m_desc, 128'h7);
    checkOutput("flush_next_pair", {127'd0, m_desc_pair}, 128'd0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_after_count", {96'd0, rec_count}, 128'd10);

    // Reset while a low word is pending
    applyStimulus(1'b1, 64'h44, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    checkOutput("rst_mid_count", {96'd0, rec_count}, 128'd0);
    checkOutput("rst_mid_valid", {127'd0, m_desc_valid}, 128'd0);
    applyStimulus(1'b1, 64'h55, 1'b0, 1'b1, 1'b0);
    checkOutput("rst_mid_data", m_desc, 128'h55);
    checkOutput("rst_mid_pair", {127'd0, m_desc_pair}, 128'd0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);

    // Counter wrap with a preloaded count
    force dut.recCount_q = 32'hFFFF_FFFF;
    countBase = 32'hFFFF_FFFF - mPops;
    #1;
    release dut.recCount_q;
    applyStimulus(1'b1, 64'h66, 1'b0, 1'b1, 1'b0);
    checkOutput("wrap_pre", {96'd0, rec_count}, 128'hFFFF_FFFF);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("wrap_post", {96'd0, rec_count}, 128'd0);

    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
